// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control definitions: ALU op and branch type encodings and the
// registered control bundle carried from ID into EX.
package mips_ctrl_pkg;

    localparam int unsigned ALU_OP_W  = 3;
    localparam int unsigned BR_TYPE_W = 2;
    localparam int unsigned CNT_W     = 16;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_RTYPE = 3'b000,
        ALU_ADD   = 3'b001,
        ALU_SUB   = 3'b010,
        ALU_SLT   = 3'b011,
        ALU_LUI   = 3'b100,
        ALU_OR    = 3'b101,
        ALU_BGEZ  = 3'b110
    } alu_op_e;

    typedef enum logic [BR_TYPE_W-1:0] {
        BR_BEQ  = 2'd0,
        BR_BGEZ = 2'd1,
        BR_BLT  = 2'd2,
        BR_BNE  = 2'd3
    } br_type_e;

    // Controls that travel with the instruction; all-zero is a bubble.
    typedef struct packed {
        logic     reg_write;
        logic     alu_src;
        logic     branch;
        logic     mem_read;
        logic     mem_write;
        logic     mem_to_reg;
        alu_op_e  alu_op;
        br_type_e branch_type;
    } ctrl_t;

    // Increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: ID-side instruction fields, flush/stall, and the registered
// EX-side outputs. Signal suffixes are from the stage's point of view.
//   master : upstream/downstream pipeline (drives id_*, flush_i)
//   slave  : the id_ex_stage itself (drives ex_*, stall_o)
interface id_ex_stage_if #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
);
    logic                  id_valid_i;
    logic [DATA_W-1:0]     id_pc_plus4_i;
    logic [DATA_W-1:0]     id_rs_data_i;
    logic [DATA_W-1:0]     id_rt_data_i;
    logic [DATA_W-1:0]     id_imm_i;
    logic [REG_ADDR_W-1:0] id_rs_addr_i;
    logic [REG_ADDR_W-1:0] id_rt_addr_i;
    logic [REG_ADDR_W-1:0] id_rd_addr_i;
    logic                  id_reg_write_i;
    logic                  id_alu_src_i;
    logic                  id_reg_dst_i;
    logic                  id_branch_i;
    logic                  id_mem_read_i;
    logic                  id_mem_write_i;
    logic                  id_mem_to_reg_i;
    logic [2:0]            id_alu_op_i;
    logic [1:0]            id_branch_type_i;
    logic                  flush_i;
    logic                  stall_o;
    logic                  ex_valid_o;
    logic [DATA_W-1:0]     ex_pc_plus4_o;
    logic [DATA_W-1:0]     ex_rs_data_o;
    logic [DATA_W-1:0]     ex_rt_data_o;
    logic [DATA_W-1:0]     ex_imm_o;
    logic [REG_ADDR_W-1:0] ex_rs_addr_o;
    logic [REG_ADDR_W-1:0] ex_rt_addr_o;
    logic [REG_ADDR_W-1:0] ex_wr_addr_o;
    logic                  ex_reg_write_o;
    logic                  ex_alu_src_o;
    logic                  ex_branch_o;
    logic                  ex_mem_read_o;
    logic                  ex_mem_write_o;
    logic                  ex_mem_to_reg_o;
    logic [2:0]            ex_alu_op_o;
    logic [1:0]            ex_branch_type_o;

    modport master (
        output id_valid_i, id_pc_plus4_i, id_rs_data_i, id_rt_data_i, id_imm_i,
               id_rs_addr_i, id_rt_addr_i, id_rd_addr_i, id_reg_write_i, id_alu_src_i,
               id_reg_dst_i, id_branch_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i,
               id_alu_op_i, id_branch_type_i, flush_i,
        input  stall_o, ex_valid_o, ex_pc_plus4_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o,
               ex_rs_addr_o, ex_rt_addr_o, ex_wr_addr_o, ex_reg_write_o, ex_alu_src_o,
               ex_branch_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o, ex_alu_op_o,
               ex_branch_type_o
    );

    modport slave (
        input  id_valid_i, id_pc_plus4_i, id_rs_data_i, id_rt_data_i, id_imm_i,
               id_rs_addr_i, id_rt_addr_i, id_rd_addr_i, id_reg_write_i, id_alu_src_i,
               id_reg_dst_i, id_branch_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i,
               id_alu_op_i, id_branch_type_i, flush_i,
        output stall_o, ex_valid_o, ex_pc_plus4_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o,
               ex_rs_addr_o, ex_rt_addr_o, ex_wr_addr_o, ex_reg_write_o, ex_alu_src_o,
               ex_branch_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o, ex_alu_op_o,
               ex_branch_type_o
    );
endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector.
//   ex_*_i : load currently in EX (valid, mem_read, destination rt)
//   id_*_i : instruction in ID (valid, source addresses, rt-usage controls)
//   hazard_o : ID reads the register the EX load is about to write
module load_use_detect #(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  ex_valid_i,
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_rt_addr_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rt_addr_i,
    input  logic                  id_alu_src_i,
    input  logic                  id_mem_write_i,
    output logic                  hazard_o
);
    logic rt_used;
    logic rs_match;
    logic rt_match;

    // rt is a source for R-type ops and as store data.
    assign rt_used  = !id_alu_src_i | id_mem_write_i;
    assign rs_match = (ex_rt_addr_i == id_rs_addr_i);
    assign rt_match = rt_used & (ex_rt_addr_i == id_rt_addr_i);

    // $zero is never a real dependency.
    assign hazard_o = ex_valid_i & ex_mem_read_i & (ex_rt_addr_i != '0) & id_valid_i &
                      (rs_match | rt_match);
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with RegDst resolution, load-use stall and flush.
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-low reset
//   id_ex  : id_ex_stage_if slave (ID fields, flush_i in; ex_*, stall_o out)
//   bubble_cnt_o / flush_cnt_o : saturating event counters, present only when
//                                HAZARD_STATS_EN is defined
module id_ex_stage
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    id_ex_stage_if.slave        id_ex
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0]    bubble_cnt_o,
    output logic [CNT_W-1:0]    flush_cnt_o
`endif
);
    logic                  hazard;
    logic                  stall;
    logic                  bubble;

    logic                  valid_q, valid_d;
    ctrl_t                 ctrl_q, ctrl_d;
    ctrl_t                 id_ctrl;
    logic [DATA_W-1:0]     pc_q, rs_data_q, rt_data_q, imm_q;
    logic [REG_ADDR_W-1:0] rs_addr_q, rt_addr_q, wr_addr_q, wr_addr_d;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .ex_valid_i     (valid_q),
        .ex_mem_read_i  (ctrl_q.mem_read),
        .ex_rt_addr_i   (rt_addr_q),
        .id_valid_i     (id_ex.id_valid_i),
        .id_rs_addr_i   (id_ex.id_rs_addr_i),
        .id_rt_addr_i   (id_ex.id_rt_addr_i),
        .id_alu_src_i   (id_ex.id_alu_src_i),
        .id_mem_write_i (id_ex.id_mem_write_i),
        .hazard_o       (hazard)
    );

    // Flush kills the ID instruction anyway, so it must not also stall.
    assign stall  = hazard & !id_ex.flush_i;
    assign bubble = stall | id_ex.flush_i;

    always_comb begin
        id_ctrl             = '0;
        id_ctrl.reg_write   = id_ex.id_reg_write_i;
        id_ctrl.alu_src     = id_ex.id_alu_src_i;
        id_ctrl.branch      = id_ex.id_branch_i;
        id_ctrl.mem_read    = id_ex.id_mem_read_i;
        id_ctrl.mem_write   = id_ex.id_mem_write_i;
        id_ctrl.mem_to_reg  = id_ex.id_mem_to_reg_i;
        id_ctrl.alu_op      = alu_op_e'(id_ex.id_alu_op_i);
        id_ctrl.branch_type = br_type_e'(id_ex.id_branch_type_i);

        valid_d = 1'b0;
        ctrl_d  = '0;
        if (!bubble) begin
            valid_d = id_ex.id_valid_i;
            ctrl_d  = id_ex.id_valid_i ? id_ctrl : '0;
        end

        wr_addr_d = id_ex.id_reg_dst_i ? id_ex.id_rd_addr_i : id_ex.id_rt_addr_i;
    end

    // Data and address fields are captured unconditionally; in a bubble they
    // are don't-care because valid and all controls are zero.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            pc_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_addr_q <= '0;
            rt_addr_q <= '0;
            wr_addr_q <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            pc_q      <= id_ex.id_pc_plus4_i;
            rs_data_q <= id_ex.id_rs_data_i;
            rt_data_q <= id_ex.id_rt_data_i;
            imm_q     <= id_ex.id_imm_i;
            rs_addr_q <= id_ex.id_rs_addr_i;
            rt_addr_q <= id_ex.id_rt_addr_i;
            wr_addr_q <= wr_addr_d;
        end
    end

    assign id_ex.stall_o          = stall;
    assign id_ex.ex_valid_o       = valid_q;
    assign id_ex.ex_pc_plus4_o    = pc_q;
    assign id_ex.ex_rs_data_o     = rs_data_q;
    assign id_ex.ex_rt_data_o     = rt_data_q;
    assign id_ex.ex_imm_o         = imm_q;
    assign id_ex.ex_rs_addr_o     = rs_addr_q;
    assign id_ex.ex_rt_addr_o     = rt_addr_q;
    assign id_ex.ex_wr_addr_o     = wr_addr_q;
    assign id_ex.ex_reg_write_o   = ctrl_q.reg_write;
    assign id_ex.ex_alu_src_o     = ctrl_q.alu_src;
    assign id_ex.ex_branch_o      = ctrl_q.branch;
    assign id_ex.ex_mem_read_o    = ctrl_q.mem_read;
    assign id_ex.ex_mem_write_o   = ctrl_q.mem_write;
    assign id_ex.ex_mem_to_reg_o  = ctrl_q.mem_to_reg;
    assign id_ex.ex_alu_op_o      = ctrl_q.alu_op;
    assign id_ex.ex_branch_type_o = ctrl_q.branch_type;

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        bubble_cnt_d = stall ? sat_inc(bubble_cnt_q) : bubble_cnt_q;
        flush_cnt_d  = id_ex.flush_i ? sat_inc(flush_cnt_q) : flush_cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign bubble_cnt_o = bubble_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus a random
// stream, with a scoreboard queue of expected EX register contents.
module tb_id_ex_stage;
    import mips_ctrl_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] pc, rs, rt, imm;
        logic [AW-1:0] rsa, rta, wra;
        logic          rw, as, br, mr, mw, m2r;
        logic [2:0]    op;
        logic [1:0]    bt;
    } ex_t;

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] pc, rs, rt, imm;
        logic [AW-1:0] rsa, rta, rda;
        logic          rw, as, rd, br, mr, mw, m2r;
        logic [2:0]    op;
        logic [1:0]    bt;
    } id_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    ex_t  mdl;
    ex_t  exp_q[$];

    always #5 clk = ~clk;

    id_ex_stage_if #(.DATA_W(DW), .REG_ADDR_W(AW)) bus ();

`ifdef HAZARD_STATS_EN
    logic [15:0] bubble_cnt;
    logic [15:0] flush_cnt;
`endif

    id_ex_stage #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .id_ex        (bus)
`ifdef HAZARD_STATS_EN
        ,
        .bubble_cnt_o (bubble_cnt),
        .flush_cnt_o  (flush_cnt)
`endif
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic id_t mk(input logic [3:0] kind, input logic [AW-1:0] rsa,
                               input logic [AW-1:0] rta, input logic [AW-1:0] rda,
                               input logic [DW-1:0] imm);
        id_t s;
        s       = '0;
        s.valid = 1'b1;
        s.pc    = 32'h0040_0000 + {imm[11:0], 2'b00};
        s.rs    = 32'h1000_0000 | {27'd0, rsa};
        s.rt    = 32'h2000_0000 | {27'd0, rta};
        s.imm   = imm;
        s.rsa   = rsa;
        s.rta   = rta;
        s.rda   = rda;
        case (kind)
            4'd0: begin s.rw = 1; s.as = 1; s.mr = 1; s.m2r = 1; s.op = ALU_ADD; end // lw
            4'd1: begin s.rw = 1; s.rd = 1; s.op = ALU_RTYPE; end                  // add
            4'd2: begin s.rw = 1; s.as = 1; s.op = ALU_ADD; end                    // addi
            4'd3: begin s.as = 1; s.mw = 1; s.op = ALU_ADD; end                    // sw
            4'd4: begin s.br = 1; s.op = ALU_SUB; s.bt = 2'd3; end                 // bne
            default: begin s = '0; s.rsa = rsa; s.rta = rta; end                   // empty slot
        endcase
        return s;
    endfunction

    function automatic ex_t sample();
        ex_t g;
        g.valid = bus.ex_valid_o;      g.pc  = bus.ex_pc_plus4_o;
        g.rs    = bus.ex_rs_data_o;    g.rt  = bus.ex_rt_data_o;
        g.imm   = bus.ex_imm_o;        g.rsa = bus.ex_rs_addr_o;
        g.rta   = bus.ex_rt_addr_o;    g.wra = bus.ex_wr_addr_o;
        g.rw    = bus.ex_reg_write_o;  g.as  = bus.ex_alu_src_o;
        g.br    = bus.ex_branch_o;     g.mr  = bus.ex_mem_read_o;
        g.mw    = bus.ex_mem_write_o;  g.m2r = bus.ex_mem_to_reg_o;
        g.op    = bus.ex_alu_op_o;     g.bt  = bus.ex_branch_type_o;
        return g;
    endfunction

    task automatic apply(input id_t s, input logic fl);
        bus.id_valid_i      = s.valid; bus.id_pc_plus4_i   = s.pc;
        bus.id_rs_data_i    = s.rs;    bus.id_rt_data_i    = s.rt;
        bus.id_imm_i        = s.imm;   bus.id_rs_addr_i    = s.rsa;
        bus.id_rt_addr_i    = s.rta;   bus.id_rd_addr_i    = s.rda;
        bus.id_reg_write_i  = s.rw;    bus.id_alu_src_i    = s.as;
        bus.id_reg_dst_i    = s.rd;    bus.id_branch_i     = s.br;
        bus.id_mem_read_i   = s.mr;    bus.id_mem_write_i  = s.mw;
        bus.id_mem_to_reg_i = s.m2r;   bus.id_alu_op_i     = s.op;
        bus.id_branch_type_i = s.bt;   bus.flush_i         = fl;
    endtask

    // One pipeline cycle: drive at negedge, check stall_o, push the expected
    // EX contents, then pop and compare them after the rising edge.
    task automatic run_cycle(input id_t s, input logic fl, output logic stall_seen);
        ex_t nxt, got, e;
        logic hz, es;
        @(negedge clk);
        apply(s, fl);
        #1;
        hz = mdl.valid && mdl.mr && (mdl.rta != 0) && s.valid &&
             ((mdl.rta == s.rsa) || ((!s.as || s.mw) && (mdl.rta == s.rta)));
        es = hz && !fl;
        n_cmp++;
        if (bus.stall_o !== es) begin
            n_err++;
            $display("FAIL stall_o: got %b expected %b", bus.stall_o, es);
        end
        stall_seen = bus.stall_o;
        nxt     = '0;
        nxt.pc  = s.pc;  nxt.rs  = s.rs;  nxt.rt = s.rt; nxt.imm = s.imm;
        nxt.rsa = s.rsa; nxt.rta = s.rta;
        nxt.wra = s.rd ? s.rda : s.rta;
        if (!(fl || es) && s.valid) begin
            nxt.valid = 1'b1;
            nxt.rw = s.rw; nxt.as = s.as; nxt.br = s.br; nxt.mr = s.mr;
            nxt.mw = s.mw; nxt.m2r = s.m2r; nxt.op = s.op; nxt.bt = s.bt;
        end
        exp_q.push_back(nxt);
        @(posedge clk);
        #1;
        got = sample();
        e   = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL ex_regs: got %h expected %h", got, e);
        end
        mdl = e;
    endtask

    task automatic test_reset();
        ex_t  got;
        logic st;
        n_cmp++;
        if (sample() !== '0 || bus.stall_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_initial: got %h stall %b expected 0", sample(), bus.stall_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_cycle(mk(4'd0, 5'd1, 5'd9, 5'd0, 32'd4), 1'b0, st);
        // Present a dependent add, then reset mid-cycle while stalling.
        @(negedge clk);
        apply(mk(4'd1, 5'd9, 5'd2, 5'd3, 32'd0), 1'b0);
        #1;
        n_cmp++;
        if (bus.stall_o !== 1'b1) begin
            n_err++;
            $display("FAIL reset_prestall: got %b expected 1", bus.stall_o);
        end
        #1 rst_n = 1'b0;
        #1;
        got = sample();
        n_cmp++;
        if (got !== '0 || bus.stall_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: got %h stall %b expected 0", got, bus.stall_o);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        n_cmp++;
        if (sample() !== '0) begin
            n_err++;
            $display("FAIL reset_held: got %h expected 0", sample());
        end
        @(negedge clk);
        rst_n = 1'b1;
        mdl = '0;
        exp_q.delete();
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats();
        logic st;
        for (int i = 0; i < 3; i++) begin
            run_cycle(mk(4'd0, 5'd1, 5'd9, 5'd0, 32'd8), 1'b0, st);
            run_cycle(mk(4'd1, 5'd9, 5'd2, 5'd3, 32'd0), 1'b0, st);
            run_cycle(mk(4'd1, 5'd9, 5'd2, 5'd3, 32'd0), 1'b0, st);
        end
        run_cycle(mk(4'd2, 5'd1, 5'd4, 5'd0, 32'd1), 1'b1, st);
        run_cycle(mk(4'd2, 5'd1, 5'd4, 5'd0, 32'd1), 1'b1, st);
        n_cmp++;
        if (bubble_cnt !== 16'd3 || flush_cnt !== 16'd2) begin
            n_err++;
            $display("FAIL stats_count: got %0d/%0d expected 3/2", bubble_cnt, flush_cnt);
        end
        @(negedge clk);
        force dut.bubble_cnt_q = 16'hFFFF;
        #1 release dut.bubble_cnt_q;
        run_cycle(mk(4'd0, 5'd1, 5'd9, 5'd0, 32'd8), 1'b0, st);
        run_cycle(mk(4'd1, 5'd9, 5'd2, 5'd3, 32'd0), 1'b0, st);
        n_cmp++;
        if (bubble_cnt !== 16'hFFFF) begin
            n_err++;
            $display("FAIL stats_saturate: got %h expected ffff", bubble_cnt);
        end
        run_cycle(mk(4'd5, 5'd0, 5'd0, 5'd0, 32'd0), 1'b0, st);
    endtask
`endif

    task automatic test_pass_through();
        logic st;
        run_cycle(mk(4'd2, 5'd4, 5'd8, 5'd0, 32'd5), 1'b0, st);
        n_cmp++;
        if (bus.ex_alu_op_o !== 3'b001 || bus.ex_alu_src_o !== 1'b1 ||
            bus.ex_wr_addr_o !== 5'd8 || bus.ex_imm_o !== 32'd5 || bus.ex_valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL pass_addi: got op %b src %b wr %0d imm %0d v %b expected 001 1 8 5 1",
                     bus.ex_alu_op_o, bus.ex_alu_src_o, bus.ex_wr_addr_o, bus.ex_imm_o,
                     bus.ex_valid_o);
        end
        run_cycle(mk(4'd1, 5'd4, 5'd8, 5'd12, 32'd0), 1'b0, st);
        n_cmp++;
        if (bus.ex_wr_addr_o !== 5'd12 || bus.ex_alu_op_o !== 3'b000) begin
            n_err++;
            $display("FAIL pass_regdst: got wr %0d op %b expected 12 000",
                     bus.ex_wr_addr_o, bus.ex_alu_op_o);
        end
        run_cycle(mk(4'd5, 5'd4, 5'd8, 5'd12, 32'd0), 1'b0, st);
        n_cmp++;
        if (bus.ex_valid_o !== 1'b0 || bus.ex_reg_write_o !== 1'b0) begin
            n_err++;
            $display("FAIL pass_invalid: got v %b rw %b expected 0 0",
                     bus.ex_valid_o, bus.ex_reg_write_o);
        end
    endtask

    task automatic test_load_use();
        logic st1, st2;
        run_cycle(mk(4'd0, 5'd1, 5'd9, 5'd0, 32'd16), 1'b0, st1);
        run_cycle(mk(4'd1, 5'd9, 5'd2, 5'd3, 32'd0), 1'b0, st1);
        n_cmp++;
        if (st1 !== 1'b1 || bus.ex_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL loaduse_stall: got stall %b v %b expected 1 0", st1, bus.ex_valid_o);
        end
        run_cycle(mk(4'd1, 5'd9, 5'd2, 5'd3, 32'd0), 1'b0, st2);
        n_cmp++;
        if (st2 !== 1'b0 || bus.ex_valid_o !== 1'b1 || bus.ex_rs_addr_o !== 5'd9) begin
            n_err++;
            $display("FAIL loaduse_release: got stall %b v %b rs %0d expected 0 1 9",
                     st2, bus.ex_valid_o, bus.ex_rs_addr_o);
        end
        // Store data via rt is a real dependency.
        run_cycle(mk(4'd0, 5'd1, 5'd7, 5'd0, 32'd16), 1'b0, st1);
        run_cycle(mk(4'd3, 5'd2, 5'd7, 5'd0, 32'd4), 1'b0, st1);
        n_cmp++;
        if (st1 !== 1'b1) begin
            n_err++;
            $display("FAIL loaduse_sw_rt: got %b expected 1", st1);
        end
    endtask

    task automatic test_exemptions();
        logic st;
        run_cycle(mk(4'd0, 5'd1, 5'd9, 5'd0, 32'd16), 1'b0, st);
        run_cycle(mk(4'd2, 5'd3, 5'd9, 5'd0, 32'd1), 1'b0, st);
        n_cmp++;
        if (st !== 1'b0) begin
            n_err++;
            $display("FAIL exempt_rt_unused: got %b expected 0", st);
        end
        run_cycle(mk(4'd0, 5'd1, 5'd0, 5'd0, 32'd16), 1'b0, st);
        run_cycle(mk(4'd1, 5'd0, 5'd0, 5'd3, 32'd0), 1'b0, st);
        n_cmp++;
        if (st !== 1'b0) begin
            n_err++;
            $display("FAIL exempt_zero: got %b expected 0", st);
        end
    endtask

    task automatic test_flush_vs_stall();
        logic st;
        run_cycle(mk(4'd0, 5'd1, 5'd9, 5'd0, 32'd16), 1'b0, st);
        run_cycle(mk(4'd1, 5'd9, 5'd2, 5'd3, 32'd0), 1'b1, st);
        n_cmp++;
        if (st !== 1'b0 || bus.ex_valid_o !== 1'b0 || bus.ex_reg_write_o !== 1'b0) begin
            n_err++;
            $display("FAIL flush_stall: got stall %b v %b rw %b expected 0 0 0",
                     st, bus.ex_valid_o, bus.ex_reg_write_o);
        end
    endtask

    task automatic test_random();
        logic st;
        for (int i = 0; i < 80; i++) begin
            run_cycle(mk(4'($urandom_range(0, 5)), 5'($urandom_range(0, 3)),
                         5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                         32'($urandom)), ($urandom_range(0, 7) == 0), st);
        end
    endtask

    initial begin
        mdl = '0;
        apply('0, 1'b0);
        test_reset();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        test_pass_through();
        test_load_use();
        test_exemptions();
        test_flush_vs_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
